uart_rx_oversample: RTL and testbench

Robust UART receiver for the pixel link. It deserialises 8N1 frames sent by the host or by the team's `uart_tx` instance at the same `BPS` and `SYS_CLK_FRE`. Each bit is sampled three times around its centre with majority vote, false starts are rejected, and bad stop bits are flagged. Received bytes go as single-cycle strobes to the pixel path (histogram equalization input).

---
 rtl/uart_rx_oversample_if.sv | 25 ++
 rtl/uart_rx_oversample.sv | 128 ++++++++++++
 tb/tb_uart_rx_oversample.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_oversample_if.sv
// Receiver-side signal bundle for the pixel-link UART.
// The slave modport is the receiver; the master modport is the line driver and byte consumer.
interface uart_rx_oversample_if;
  logic       uart_rxd;
  logic       uart_rx_done;
  logic [7:0] uart_rx_data;
  logic       uart_frame_err;
  logic       uart_rx_busy;

  modport master (
    output uart_rxd,
    input  uart_rx_done,
    input  uart_rx_data,
    input  uart_frame_err,
    input  uart_rx_busy
  );

  modport slave (
    input  uart_rxd,
    output uart_rx_done,
    output uart_rx_data,
    output uart_frame_err,
    output uart_rx_busy
  );
endinterface

// File: rtl/uart_rx_oversample.sv
// 8N1 UART receiver with 3-sample majority vote, false-start rejection and
// stop-bit error flagging; bytes leave as single-cycle strobes.
//
//   state | meaning
//   IDLE  | line idle, waiting for a falling edge
//   START | timing the start bit; a high majority aborts as a false start
//   DATA  | shifting in data bits 1..8, LSB first
//   STOP  | sampling the stop bit; leaves at the decision point
module uart_rx_oversample #(
  parameter int BPS         = 921600,
  parameter int SYS_CLK_FRE = 50_000_000
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  uart_rx_oversample_if.slave  uart
);
  localparam int BIT_CNT = SYS_CLK_FRE / BPS;
  localparam int HALF    = BIT_CNT / 2;
  localparam int CW      = $clog2(BIT_CNT);

  if (BIT_CNT < 8) begin : g_bit_cnt_check
    $error("uart_rx_oversample: SYS_CLK_FRE/BPS must be at least 8");
  end

  // Compares run against the current cnt, so each sample lands on the edge
  // that moves cnt to HALF-1, HALF and HALF+1 respectively.
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0] CNT_S0   = CW'(HALF - 2);
  localparam logic [CW-1:0] CNT_S1   = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_DEC  = CW'(HALF);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic          sync1, sync2, sync3;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx;
  logic          samp0, samp1;
  logic [7:0]    shift_q;
  logic [7:0]    rx_data;
  logic          rx_done, frame_err;
  logic          fall, wrap, decide, maj;
  logic          shift_en, done_set, err_set;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      sync3 <= 1'b1;
    end else begin
      sync1 <= uart.uart_rxd;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign fall   = ~sync2 & sync3;
  assign wrap   = (cnt == CNT_LAST);
  assign decide = (cnt == CNT_DEC);
  assign maj    = (samp0 & samp1) | (samp0 & sync2) | (samp1 & sync2);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fall) state_nxt = START;
      START: begin
        if (decide && maj) state_nxt = IDLE;
        else if (wrap)     state_nxt = DATA;
      end
      DATA:    if (wrap && bit_idx == 4'd8) state_nxt = STOP;
      STOP:    if (decide) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    shift_en = 1'b0;
    done_set = 1'b0;
    err_set  = 1'b0;
    case (state)
      DATA: shift_en = decide;
      STOP: begin
        done_set = decide & maj;
        err_set  = decide & ~maj;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt       <= '0;
      bit_idx   <= '0;
      samp0     <= 1'b1;
      samp1     <= 1'b1;
      shift_q   <= '0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_done   <= done_set;
      frame_err <= err_set;
      if (state == IDLE || state_nxt == IDLE) begin
        cnt     <= '0;
        bit_idx <= '0;
      end else if (wrap) begin
        cnt     <= '0;
        bit_idx <= bit_idx + 4'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (cnt == CNT_S0) samp0 <= sync2;
      if (cnt == CNT_S1) samp1 <= sync2;
      if (shift_en) shift_q <= {maj, shift_q[7:1]};
      if (done_set) rx_data <= shift_q;
    end
  end

  assign uart.uart_rx_done   = rx_done;
  assign uart.uart_rx_data   = rx_data;
  assign uart.uart_frame_err = frame_err;
  assign uart.uart_rx_busy   = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample: single frames, back-to-back frames,
// glitches, framing errors, +/-2 % baud ramps and mid-frame reset.
module tb_uart_rx_oversample;
  logic sys_clk = 1'b0;
  logic sys_rst_n;
  uart_rx_oversample_if bus ();

  uart_rx_oversample dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .uart      (bus)
  );

  always #10 sys_clk = ~sys_clk;

  int         cyc = 0;
  int         n_vec = 0;
  int         n_miss = 0;
  logic [7:0] rx_q[$];
  int         done_cyc = 0;
  int         start_cyc = 0;
  int         err_cnt = 0;
  int         both_cnt = 0;
  int         long_done = 0;
  int         long_err = 0;
  int         busy_rise = 0;
  int         data_glitch = 0;
  logic       prev_done = 1'b0, prev_err = 1'b0, prev_busy = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(posedge sys_clk) cyc++;

  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (bus.uart_rx_done) begin
        rx_q.push_back(bus.uart_rx_data);
        done_cyc = cyc;
      end
      if (bus.uart_frame_err) err_cnt++;
      if (bus.uart_rx_done && bus.uart_frame_err) both_cnt++;
      if (bus.uart_rx_done && prev_done) long_done++;
      if (bus.uart_frame_err && prev_err) long_err++;
      if (bus.uart_rx_busy && !prev_busy) busy_rise++;
      if (bus.uart_rx_data !== prev_data && !bus.uart_rx_done) data_glitch++;
    end
    prev_done = bus.uart_rx_done;
    prev_err  = bus.uart_frame_err;
    prev_busy = bus.uart_rx_busy;
    prev_data = bus.uart_rx_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int per);
    bus.uart_rxd = v;
    repeat (per) @(negedge sys_clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int per, input logic stop_val);
    start_cyc = cyc;
    drive_bit(1'b0, per);
    for (int i = 0; i < 8; i++) drive_bit(b[i], per);
    drive_bit(stop_val, per);
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge sys_clk);
      k++;
    end
    check("rx_count", rx_q.size(), n);
  endtask

  initial begin
    int lat;
    int base;
    int errs;
    bus.uart_rxd = 1'b1;
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("rst_done", bus.uart_rx_done, 0);
    check("rst_err", bus.uart_frame_err, 0);
    check("rst_busy", bus.uart_rx_busy, 0);
    check("rst_data", bus.uart_rx_data, 8'h00);
    sys_rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);

    // single frame, latency from start edge
    send_byte(8'hA5, 54, 1'b1);
    wait_rx(1, 100);
    check("a5_data", rx_q[0], 8'hA5);
    check("a5_port", bus.uart_rx_data, 8'hA5);
    lat = done_cyc - start_cyc;
    n_vec++;
    assert (lat >= 515 && lat <= 519) else begin
      n_miss++;
      $error("FAIL latency: observed %0d expected 517 +-2", lat);
    end
    check("a5_err", err_cnt, 0);
    check("a5_busy", bus.uart_rx_busy, 0);
    drive_bit(1'b1, 20);

    // back-to-back, no idle bits
    send_byte(8'h00, 54, 1'b1);
    send_byte(8'hFF, 54, 1'b1);
    send_byte(8'h55, 54, 1'b1);
    wait_rx(4, 200);
    check("b2b_0", rx_q[1], 8'h00);
    check("b2b_1", rx_q[2], 8'hFF);
    check("b2b_2", rx_q[3], 8'h55);
    check("b2b_err", err_cnt, 0);
    drive_bit(1'b1, 20);

    // 10-cycle glitch must be rejected as a false start
    base = busy_rise;
    drive_bit(1'b0, 10);
    check("glitch_busy_hi", bus.uart_rx_busy, 1);
    drive_bit(1'b1, 60);
    check("glitch_busy_lo", bus.uart_rx_busy, 0);
    check("glitch_rise", busy_rise, base + 1);
    check("glitch_done", rx_q.size(), 4);
    check("glitch_err", err_cnt, 0);
    send_byte(8'h3C, 54, 1'b1);
    wait_rx(5, 100);
    check("post_glitch", rx_q[4], 8'h3C);
    drive_bit(1'b1, 20);

    // framing error followed by a held break
    send_byte(8'hA5, 54, 1'b1);
    wait_rx(6, 100);
    check("pre_ferr", rx_q[5], 8'hA5);
    send_byte(8'h3C, 54, 1'b0);
    drive_bit(1'b0, 600);
    check("ferr_cnt", err_cnt, 1);
    check("ferr_no_done", rx_q.size(), 6);
    check("ferr_data", bus.uart_rx_data, 8'hA5);
    drive_bit(1'b1, 60);
    check("break_err", err_cnt, 1);

    // sender 2 % fast (53-cycle bits)
    base = rx_q.size();
    for (int i = 0; i < 64; i++) send_byte(8'(i * 4), 53, 1'b1);
    wait_rx(base + 64, 200);
    errs = 0;
    for (int i = 0; i < 64; i++) begin
      n_vec++;
      assert (rx_q[base + i] === 8'(i * 4)) else begin
        n_miss++;
        errs++;
        $error("FAIL ramp_fast[%0d]: observed %0h expected %0h", i, rx_q[base + i], 8'(i * 4));
      end
    end
    check("ramp_fast_err", err_cnt, 1);
    drive_bit(1'b1, 20);

    // sender 2 % slow (55-cycle bits)
    base = rx_q.size();
    for (int i = 0; i < 64; i++) send_byte(8'(i * 4 + 3), 55, 1'b1);
    wait_rx(base + 64, 200);
    for (int i = 0; i < 64; i++) begin
      n_vec++;
      assert (rx_q[base + i] === 8'(i * 4 + 3)) else begin
        n_miss++;
        errs++;
        $error("FAIL ramp_slow[%0d]: observed %0h expected %0h", i, rx_q[base + i], 8'(i * 4 + 3));
      end
    end
    check("ramp_slow_err", err_cnt, 1);
    drive_bit(1'b1, 20);

    // reset during data bit 4 of an F0 frame; line stays high afterwards
    base = rx_q.size();
    drive_bit(1'b0, 54);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 54);
    drive_bit(1'b1, 20);
    check("pre_rst_busy", bus.uart_rx_busy, 1);
    sys_rst_n = 1'b0;
    #1;
    check("mid_rst_busy", bus.uart_rx_busy, 0);
    check("mid_rst_done", bus.uart_rx_done, 0);
    check("mid_rst_err", bus.uart_frame_err, 0);
    check("mid_rst_data", bus.uart_rx_data, 8'h00);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    drive_bit(1'b1, 34 + 3 * 54 + 54 + 100);
    check("broken_no_done", rx_q.size(), base);
    check("broken_no_err", err_cnt, 1);
    send_byte(8'h81, 54, 1'b1);
    wait_rx(base + 1, 100);
    check("post_rst_data", rx_q[base], 8'h81);
    check("post_rst_port", bus.uart_rx_data, 8'h81);
    drive_bit(1'b1, 20);

    check("both_strobes", both_cnt, 0);
    check("done_width", long_done, 0);
    check("err_width", long_err, 0);
    check("data_stable", data_glitch, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
